// File: rtl/jtcop_pkg.sv
// Shared definitions for the Dec0 68000 bus responder: FSM states, target
// priority order and read-class encoding.
package jtcop_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_FAST,
        ST_SLOW,
        ST_ACK
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_FAST,
        CLS_SLOW
    } cls_t;

    // Target indices, lowest index wins when several selects are active
    localparam int T_ROM    = 0;
    localparam int T_SYSRAM = 1;
    localparam int T_HUC    = 2;
    localparam int T_OBJ    = 3;
    localparam int T_PAL    = 4;
    localparam int T_DISP   = 5;
    localparam int T_CAB    = 6;
    localparam int T_SYS    = 7;
    localparam int T_DIP    = 8;
    localparam int T_PROT   = 9;
    localparam int NUM_TGT  = 10;

    localparam logic [15:0] OPEN_BUS_DEF = 16'hFFFF;

    // SDRAM and HuC targets need a handshake; everything else is on-chip
    function automatic cls_t tgt_class(input int idx);
        if (idx == T_ROM || idx == T_SYSRAM || idx == T_HUC)
            return CLS_SLOW;
        return CLS_FAST;
    endfunction

endpackage

// File: rtl/jtcop_dtack_mux.sv
// Priority read-data mux: picks the highest-priority active select and
// reports its data, access class and (for handshaked targets) its ok flag.
module jtcop_dtack_mux
    import jtcop_pkg::*;
#(
    parameter logic [15:0] OPEN_BUS = OPEN_BUS_DEF
) (
    input  logic        rom_cs,
    input  logic        rom_ok,
    input  logic [15:0] rom_data,
    input  logic        sysram_cs,
    input  logic        ram_ok,
    input  logic [15:0] ram_data,
    input  logic        huc_cs,
    input  logic        huc_ok,
    input  logic [7:0]  huc_dout,
    input  logic        obj_cs,
    input  logic [15:0] obj_dout,
    input  logic [1:0]  pal_cs,
    input  logic [15:0] pal_dout,
    input  logic        disp_cs,
    input  logic [15:0] disp_dout,
    input  logic [2:0]  read_cs,
    input  logic [15:0] cab_io,
    input  logic [15:0] sys_io,
    input  logic [15:0] dipsw,
    input  logic        nexrm0_cs,
    input  logic [15:0] prot_dout,
    output logic [15:0] dout,
    output cls_t        cls,
    output logic        ok
);

    logic [NUM_TGT-1:0]       sel;
    logic [NUM_TGT-1:0]       tok;
    logic [NUM_TGT-1:0][15:0] tdat;

    always_comb begin
        sel  = '0;
        tok  = '1;
        tdat = '0;
        sel[T_ROM]    = rom_cs;     tdat[T_ROM]    = rom_data;  tok[T_ROM]    = rom_ok;
        sel[T_SYSRAM] = sysram_cs;  tdat[T_SYSRAM] = ram_data;  tok[T_SYSRAM] = ram_ok;
        sel[T_HUC]    = huc_cs;     tdat[T_HUC]    = {8'hFF, huc_dout};
        tok[T_HUC]    = huc_ok;
        sel[T_OBJ]    = obj_cs;     tdat[T_OBJ]    = obj_dout;
        sel[T_PAL]    = |pal_cs;    tdat[T_PAL]    = pal_dout;
        sel[T_DISP]   = disp_cs;    tdat[T_DISP]   = disp_dout;
        sel[T_CAB]    = read_cs[0]; tdat[T_CAB]    = cab_io;
        sel[T_SYS]    = read_cs[1]; tdat[T_SYS]    = sys_io;
        sel[T_DIP]    = read_cs[2]; tdat[T_DIP]    = dipsw;
        sel[T_PROT]   = nexrm0_cs;  tdat[T_PROT]   = prot_dout;
    end

    // Scan from lowest priority up so the highest-priority hit lands last
    always_comb begin
        dout = OPEN_BUS;
        cls  = CLS_NONE;
        ok   = 1'b0;
        for (int i = NUM_TGT-1; i >= 0; i--) begin
            if (sel[i]) begin
                dout = tdat[i];
                cls  = tgt_class(i);
                ok   = tok[i];
            end
        end
    end

endmodule

// File: rtl/jtcop_dtack.sv
// 68000 DTACK generator for Dec0/Sly Spy: per-target wait states, latched
// read data and a bounded wait so a stuck handshake cannot hang the CPU.
module jtcop_dtack
    import jtcop_pkg::*;
#(
    parameter int          FAST_WAIT = 2,
    parameter int          TIMEOUT   = 255,
    parameter logic [15:0] OPEN_BUS  = OPEN_BUS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ASn,
    input  logic        UDSn,
    input  logic        LDSn,
    input  logic        RnW,
    input  logic        rom_cs,
    input  logic        rom_ok,
    input  logic [15:0] rom_data,
    input  logic        sysram_cs,
    input  logic        ram_ok,
    input  logic [15:0] ram_data,
    input  logic        obj_cs,
    input  logic [15:0] obj_dout,
    input  logic [1:0]  pal_cs,
    input  logic [15:0] pal_dout,
    input  logic        disp_cs,
    input  logic [15:0] disp_dout,
    input  logic [2:0]  read_cs,
    input  logic [15:0] cab_io,
    input  logic [15:0] sys_io,
    input  logic [15:0] dipsw,
    input  logic        huc_cs,
    input  logic        huc_ok,
    input  logic [7:0]  huc_dout,
    input  logic        nexrm0_cs,
    input  logic [15:0] prot_dout,
    output logic        DTACKn,
    output logic [15:0] cpu_din,
    output logic        bus_err
);

    localparam logic [7:0] FW_CNT = 8'(FAST_WAIT - 1);
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t      state, state_nx;
    cls_t        cls;
    logic [15:0] mux_dout;
    logic        mux_ok;
    logic [7:0]  cnt;
    logic        strobe, strobe_l, start;
    logic        timeout;
    logic [15:0] ack_data;
    logic        ack_rd;

    jtcop_dtack_mux #(.OPEN_BUS(OPEN_BUS)) u_mux (
        .rom_cs    (rom_cs),
        .rom_ok    (rom_ok),
        .rom_data  (rom_data),
        .sysram_cs (sysram_cs),
        .ram_ok    (ram_ok),
        .ram_data  (ram_data),
        .huc_cs    (huc_cs),
        .huc_ok    (huc_ok),
        .huc_dout  (huc_dout),
        .obj_cs    (obj_cs),
        .obj_dout  (obj_dout),
        .pal_cs    (pal_cs),
        .pal_dout  (pal_dout),
        .disp_cs   (disp_cs),
        .disp_dout (disp_dout),
        .read_cs   (read_cs),
        .cab_io    (cab_io),
        .sys_io    (sys_io),
        .dipsw     (dipsw),
        .nexrm0_cs (nexrm0_cs),
        .prot_dout (prot_dout),
        .dout      (mux_dout),
        .cls       (cls),
        .ok        (mux_ok)
    );

    assign strobe  = ASn | (UDSn & LDSn);
    assign start   = strobe_l & ~strobe;
    assign timeout = (state == ST_SLOW) && !mux_ok && (cnt >= TO_CNT);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (start) state_nx = ST_SETTLE;
            ST_SETTLE: begin
                case (cls)
                    CLS_SLOW: state_nx = ST_SLOW;
                    CLS_FAST: state_nx = ST_FAST;
                    default:  state_nx = ST_ACK;
                endcase
            end
            ST_FAST:   if (cnt >= FW_CNT) state_nx = ST_ACK;
            ST_SLOW:   if (mux_ok || timeout) state_nx = ST_ACK;
            ST_ACK:    state_nx = ST_ACK;
            default:   state_nx = ST_IDLE;
        endcase
        // Address strobe released ends (or aborts) the cycle from any state
        if (ASn) state_nx = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            // Treat the strobe as active so a cycle interrupted by reset
            // needs a fresh falling edge before it can be acknowledged
            strobe_l <= 1'b0;
            cnt      <= '0;
            DTACKn   <= 1'b1;
            cpu_din  <= '0;
            bus_err  <= 1'b0;
            ack_data <= '0;
            ack_rd   <= 1'b0;
        end else begin
            state    <= state_nx;
            strobe_l <= strobe;

            if (state == ST_IDLE && state_nx == ST_SETTLE)
                cnt <= '0;
            else if ((state == ST_SETTLE || state == ST_FAST || state == ST_SLOW)
                     && cnt != 8'hFF)
                cnt <= cnt + 8'd1;

            if (state != ST_ACK && state_nx == ST_ACK) begin
                ack_data <= timeout ? OPEN_BUS : mux_dout;
                ack_rd   <= RnW;
            end

            if (timeout && state_nx == ST_ACK)
                bus_err <= 1'b1;

            DTACKn <= !(state == ST_ACK && !ASn);
            if (state == ST_ACK && !ASn && ack_rd)
                cpu_din <= ack_data;
        end
    end

endmodule

// File: tb/tb_jtcop_dtack.sv
// Directed bench for jtcop_dtack: latency per target class, data mux,
// timeout, abort and reset behaviour.
module tb_jtcop_dtack;

    logic        clk = 1'b0;
    logic        rst;
    logic        ASn, UDSn, LDSn, RnW;
    logic        rom_cs, rom_ok;
    logic [15:0] rom_data;
    logic        sysram_cs, ram_ok;
    logic [15:0] ram_data;
    logic        obj_cs;
    logic [15:0] obj_dout;
    logic [1:0]  pal_cs;
    logic [15:0] pal_dout;
    logic        disp_cs;
    logic [15:0] disp_dout;
    logic [2:0]  read_cs;
    logic [15:0] cab_io, sys_io, dipsw;
    logic        huc_cs, huc_ok;
    logic [7:0]  huc_dout;
    logic        nexrm0_cs;
    logic [15:0] prot_dout;
    logic        DTACKn;
    logic [15:0] cpu_din;
    logic        bus_err;

    int total = 0;
    int bad   = 0;
    int ecount;
    int lat;

    always #5 clk = ~clk;

    jtcop_dtack dut (
        .clk(clk), .rst(rst), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RnW(RnW),
        .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_data(rom_data),
        .sysram_cs(sysram_cs), .ram_ok(ram_ok), .ram_data(ram_data),
        .obj_cs(obj_cs), .obj_dout(obj_dout), .pal_cs(pal_cs), .pal_dout(pal_dout),
        .disp_cs(disp_cs), .disp_dout(disp_dout), .read_cs(read_cs),
        .cab_io(cab_io), .sys_io(sys_io), .dipsw(dipsw),
        .huc_cs(huc_cs), .huc_ok(huc_ok), .huc_dout(huc_dout),
        .nexrm0_cs(nexrm0_cs), .prot_dout(prot_dout),
        .DTACKn(DTACKn), .cpu_din(cpu_din), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One posedge, then settle at the following negedge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        ecount++;
    endtask

    task automatic clr_cs();
        rom_cs = 0; sysram_cs = 0; obj_cs = 0; pal_cs = 0; disp_cs = 0;
        read_cs = 0; huc_cs = 0; nexrm0_cs = 0;
        rom_ok = 0; ram_ok = 0; huc_ok = 0;
    endtask

    // Driven at a negedge; the next posedge is edge 0 of the cycle
    task automatic start_cycle(input logic rnw);
        ASn = 0; UDSn = 0; LDSn = 0; RnW = rnw;
        ecount = -1;
    endtask

    task automatic end_cycle();
        ASn = 1; UDSn = 1; LDSn = 1; RnW = 1;
        tick();
        clr_cs();
    endtask

    // Returns the edge index (from cycle start) after which DTACKn is low
    task automatic wait_ack(input int limit, output int l);
        while (DTACKn !== 1'b0 && ecount < limit) tick();
        l = (DTACKn === 1'b0) ? ecount : -1;
    endtask

    initial begin
        rst = 1; ASn = 1; UDSn = 1; LDSn = 1; RnW = 1;
        clr_cs();
        rom_data = 16'h1234; ram_data = 16'h7777; obj_dout = 16'h0B0B;
        pal_dout = 16'h2222; disp_dout = 16'h3333; cab_io = 16'h5A0F;
        sys_io = 16'h4444; dipsw = 16'hA5C3; huc_dout = 8'h3C; prot_dout = 16'h6666;
        @(negedge clk); tick(); tick();
        rst = 0;
        tick();
        chk("rst_dtack", DTACKn, 1);
        chk("rst_din", cpu_din, 0);
        chk("rst_err", bus_err, 0);

        // ROM read, ok seen at edge 7
        rom_cs = 1;
        start_cycle(1);
        repeat (7) tick();
        chk("rom_wait", DTACKn, 1);
        rom_ok = 1;
        wait_ack(50, lat);
        chk("rom_lat", lat, 8);
        chk("rom_din", cpu_din, 16'h1234);
        rom_ok = 0;
        tick(); tick();
        chk("rom_hold", DTACKn, 0);
        chk("rom_hold_din", cpu_din, 16'h1234);
        end_cycle();
        chk("rom_release", DTACKn, 1);
        tick(); tick();

        // Unmapped read
        start_cycle(1);
        wait_ack(50, lat);
        chk("unmap_lat", lat, 2);
        chk("unmap_din", cpu_din, 16'hFFFF);
        chk("unmap_err", bus_err, 0);
        end_cycle(); tick();

        // DIP read, fast path
        read_cs = 3'b100;
        start_cycle(1);
        wait_ack(50, lat);
        chk("dip_lat", lat, 3);
        chk("dip_din", cpu_din, 16'hA5C3);
        end_cycle(); tick();

        // RAM write with no ok: timeout
        sysram_cs = 1;
        start_cycle(0);
        wait_ack(400, lat);
        chk("to_lat", lat, 257);
        chk("to_err", bus_err, 1);
        chk("to_wr_din", cpu_din, 16'hA5C3);
        end_cycle(); tick();

        // Cabinet read after the timeout
        read_cs = 3'b001;
        start_cycle(1);
        wait_ack(50, lat);
        chk("cab_lat", lat, 3);
        chk("cab_din", cpu_din, 16'h5A0F);
        chk("cab_err", bus_err, 1);
        end_cycle(); tick();

        // HuC read, ok seen at edge 4
        huc_cs = 1;
        start_cycle(1);
        repeat (4) tick();
        huc_ok = 1;
        wait_ack(50, lat);
        chk("huc_lat", lat, 5);
        chk("huc_din", cpu_din, 16'hFF3C);
        end_cycle(); tick();

        // HuC read aborted mid-wait
        huc_cs = 1;
        start_cycle(1);
        repeat (3) tick();
        ASn = 1; UDSn = 1; LDSn = 1;
        tick();
        huc_ok = 1;
        repeat (4) tick();
        chk("abort_dtack", DTACKn, 1);
        chk("abort_din", cpu_din, 16'hFF3C);
        clr_cs(); tick();
        read_cs = 3'b010;
        start_cycle(1);
        wait_ack(50, lat);
        chk("post_abort_lat", lat, 3);
        chk("post_abort_din", cpu_din, 16'h4444);
        end_cycle(); tick();

        // ROM and obj together: ROM wins, ok already high
        rom_cs = 1; obj_cs = 1; rom_ok = 1; rom_data = 16'hBEEF;
        start_cycle(1);
        wait_ack(50, lat);
        chk("prio_lat", lat, 3);
        chk("prio_din", cpu_din, 16'hBEEF);
        end_cycle(); tick();

        // Reset during ACK; strobes stay low afterwards
        read_cs = 3'b100;
        start_cycle(1);
        wait_ack(50, lat);
        chk("pre_rst_din", cpu_din, 16'hA5C3);
        rst = 1;
        tick();
        chk("mid_rst_dtack", DTACKn, 1);
        chk("mid_rst_din", cpu_din, 0);
        chk("mid_rst_err", bus_err, 0);
        rst = 0;
        repeat (6) tick();
        chk("no_reack", DTACKn, 1);
        end_cycle(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
